dump_ctrl: RTL

DUMP_CTRL -- requirements
Module: dump_ctrl

---
 rtl/dump_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dump_ctrl.sv
// dump_ctrl: streams ENTRIES samples of one capture channel to a UART, oldest sample first.
// Per byte READ -> LATCH -> SEND -> WAIT_TX (4 cycles min); invalid requests pulse dump_err.
module dump_ctrl #(
   parameter int ADDR_W  = 9,
   parameter int ENTRIES = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_dump,
   input  logic [1:0]        dump_channel,
   input  logic              capture_done,
   input  logic [ADDR_W-1:0] trace_end,
   input  logic [7:0]        rdata0,
   input  logic [7:0]        rdata1,
   input  logic [7:0]        rdata2,
   output logic [2:0]        ram_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        tx_data,
   output logic              trmt,
   input  logic              tx_done,
   output logic              dump_busy,
   output logic              dump_finished,
   output logic              dump_err
);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      LATCH,
      SEND,
      WAIT_TX,
      FIN
   } state_t;

   localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(ENTRIES - 1);

   state_t            r_state;
   state_t            w_next;
   logic [1:0]        r_chan;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_count;
   logic [7:0]        r_tx_data;
   logic              r_err;

   logic              w_req_ok;
   logic              w_accept;
   logic              w_reject;
   logic              w_last;
   logic [ADDR_W-1:0] w_first_addr;
   logic [ADDR_W-1:0] w_addr_inc;
   logic [7:0]        w_rdata;

   // The oldest sample sits just after the newest one in the circular capture RAM.
   assign w_req_ok     = capture_done && (dump_channel != 2'd3);
   assign w_accept     = (r_state == IDLE) && start_dump && w_req_ok;
   assign w_reject     = (r_state == IDLE) && start_dump && !w_req_ok;
   assign w_last       = (r_count == LP_LAST);
   assign w_first_addr = (trace_end >= LP_LAST) ? '0 : trace_end + ADDR_W'(1);
   assign w_addr_inc   = (r_addr == LP_LAST) ? '0 : r_addr + ADDR_W'(1);

   always_comb begin
      w_rdata = 8'h00;
      case (r_chan)
         2'd0:    w_rdata = rdata0;
         2'd1:    w_rdata = rdata1;
         2'd2:    w_rdata = rdata2;
         default: w_rdata = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Outputs depend on state and latched channel only, never directly on inputs.
   always_comb begin
      w_next        = r_state;
      ram_en        = 3'b000;
      trmt          = 1'b0;
      dump_finished = 1'b0;
      dump_busy     = (r_state != IDLE);
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_next = READ;
            end
         end
         READ: begin
            ram_en = 3'b001 << r_chan;
            w_next = LATCH;
         end
         LATCH: begin
            w_next = SEND;
         end
         SEND: begin
            trmt   = 1'b1;
            w_next = WAIT_TX;
         end
         WAIT_TX: begin
            if (tx_done) begin
               w_next = w_last ? FIN : READ;
            end
         end
         FIN: begin
            dump_finished = 1'b1;
            w_next        = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_chan    <= 2'd0;
         r_addr    <= '0;
         r_count   <= '0;
         r_tx_data <= 8'h00;
         r_err     <= 1'b0;
      end else begin
         r_err <= w_reject;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_chan  <= dump_channel;
                  r_addr  <= w_first_addr;
                  r_count <= '0;
               end
            end
            LATCH: begin
               r_tx_data <= w_rdata;
            end
            WAIT_TX: begin
               if (tx_done && !w_last) begin
                  r_count <= r_count + ADDR_W'(1);
                  r_addr  <= w_addr_inc;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign ram_addr = r_addr;
   assign tx_data  = r_tx_data;
   assign dump_err = r_err;

endmodule
